// File: rtl/axi_llc_flush_seq.sv
// axi_llc_flush_seq
//   Walks every set of each way named in a flush command, one Flush request
//   to the tag store per set. Dirty-valid lines come back as eviction
//   descriptors for the write-back path. Ways are handled lowest first, and
//   each one is marked in flushed_o once its last set is done.
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   flush_way_i/valid_i/ready_o   command: mask of ways to flush
//   store_*_o / store_ready_i     Flush request (one-hot way + set index)
//   store_res_*                   response: evict flag + stored tag
//   evict_*                       eviction descriptor to write-back
//   flushed_o                     sticky per-way flushed status
//   busy_o, done_o                command in progress / completion pulse
module axi_llc_flush_seq #(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned NumLines         = 256,
  parameter int unsigned IndexLength      = $clog2(NumLines),
  parameter int unsigned TagLength        = 20
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [SetAssociativity-1:0] flush_way_i,
  input  logic                        flush_valid_i,
  output logic                        flush_ready_o,
  output logic                        store_valid_o,
  input  logic                        store_ready_i,
  output logic [SetAssociativity-1:0] store_indicator_o,
  output logic [IndexLength-1:0]      store_index_o,
  input  logic                        store_res_valid_i,
  output logic                        store_res_ready_o,
  input  logic                        store_res_evict_i,
  input  logic [TagLength-1:0]        store_res_tag_i,
  output logic                        evict_valid_o,
  input  logic                        evict_ready_i,
  output logic [SetAssociativity-1:0] evict_way_o,
  output logic [IndexLength-1:0]      evict_index_o,
  output logic [TagLength-1:0]        evict_tag_o,
  output logic [SetAssociativity-1:0] flushed_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, EVICT} state_t;

  state_t                        state, state_nxt;
  logic [SetAssociativity-1:0]   pending, flushed, cur, pend_clr;
  logic [IndexLength-1:0]        index;
  logic [SetAssociativity-1:0]   ev_way;
  logic [IndexLength-1:0]        ev_index;
  logic [TagLength-1:0]          ev_tag;
  logic                          done;
  logic                          advance, last;

  // Lowest set bit of the pending mask selects the way being walked.
  assign cur      = pending & (~pending + SetAssociativity'(1));
  assign pend_clr = pending & ~cur;
  assign last     = (index == IndexLength'(NumLines - 1));
  // A set is finished when its clean response lands or its eviction is taken.
  assign advance  = (state == RESP  && store_res_valid_i && !store_res_evict_i) ||
                    (state == EVICT && evict_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    flush_ready_o     = 1'b0;
    store_valid_o     = 1'b0;
    store_res_ready_o = 1'b0;
    evict_valid_o     = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so every output reads zero there.
        flush_ready_o = !rst_i;
        if (flush_valid_i && flush_way_i != '0) state_nxt = REQ;
      end
      REQ: begin
        store_valid_o = 1'b1;
        if (store_ready_i) state_nxt = RESP;
      end
      RESP: begin
        store_res_ready_o = 1'b1;
        if (store_res_valid_i) begin
          if (store_res_evict_i)           state_nxt = EVICT;
          else if (last && pend_clr == '0) state_nxt = IDLE;
          else                             state_nxt = REQ;
        end
      end
      EVICT: begin
        evict_valid_o = 1'b1;
        if (evict_ready_i) state_nxt = (last && pend_clr == '0) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending  <= '0;
      flushed  <= '0;
      index    <= '0;
      ev_way   <= '0;
      ev_index <= '0;
      ev_tag   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && flush_valid_i) begin
        pending <= flush_way_i;
        flushed <= flushed & ~flush_way_i;
        index   <= '0;
        done    <= (flush_way_i == '0);
      end
      if (state == RESP && store_res_valid_i && store_res_evict_i) begin
        ev_way   <= cur;
        ev_index <= index;
        ev_tag   <= store_res_tag_i;
      end
      if (advance) begin
        if (last) begin
          flushed <= flushed | cur;
          pending <= pend_clr;
          index   <= '0;
          if (pend_clr == '0) done <= 1'b1;
        end else begin
          index <= index + IndexLength'(1);
        end
      end
    end
  end

  assign store_indicator_o = cur;
  assign store_index_o     = index;
  assign evict_way_o       = ev_way;
  assign evict_index_o     = ev_index;
  assign evict_tag_o       = ev_tag;
  assign flushed_o         = flushed;
  assign busy_o            = (state != IDLE);
  assign done_o            = done;

endmodule

// File: tb/tb_axi_llc_flush_seq.sv
// Randomized bench for axi_llc_flush_seq. The bench plays tag store and
// write-back path; a transaction-level model (queues of expected requests
// and evictions, plus expected flushed mask) predicts every output.
module tb_axi_llc_flush_seq;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IL = 2;
  localparam int TL = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  flush_way_i;
  logic          flush_valid_i, flush_ready_o;
  logic          store_valid_o, store_ready_i;
  logic [W-1:0]  store_indicator_o;
  logic [IL-1:0] store_index_o;
  logic          store_res_valid_i, store_res_ready_o, store_res_evict_i;
  logic [TL-1:0] store_res_tag_i;
  logic          evict_valid_o, evict_ready_i;
  logic [W-1:0]  evict_way_o;
  logic [IL-1:0] evict_index_o;
  logic [TL-1:0] evict_tag_o;
  logic [W-1:0]  flushed_o;
  logic          busy_o, done_o;

  axi_llc_flush_seq #(.SetAssociativity(W), .NumLines(N), .IndexLength(IL), .TagLength(TL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .flush_way_i(flush_way_i), .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .store_valid_o(store_valid_o), .store_ready_i(store_ready_i),
    .store_indicator_o(store_indicator_o), .store_index_o(store_index_o),
    .store_res_valid_i(store_res_valid_i), .store_res_ready_o(store_res_ready_o),
    .store_res_evict_i(store_res_evict_i), .store_res_tag_i(store_res_tag_i),
    .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
    .evict_way_o(evict_way_o), .evict_index_o(evict_index_o), .evict_tag_o(evict_tag_o),
    .flushed_o(flushed_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [W-1:0] way; logic [IL-1:0] idx; } rq_t;
  typedef struct packed { logic [W-1:0] way; logic [IL-1:0] idx; logic [TL-1:0] tag; } ev_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] flushed_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush_valid_i = 0; flush_way_i = '0; store_ready_i = 0; store_res_valid_i = 0;
    store_res_evict_i = 0; store_res_tag_i = '0; evict_ready_i = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_ready"},  flush_ready_o, 0);
    chk({pfx, "_sval"},   store_valid_o, 0);
    chk({pfx, "_rrdy"},   store_res_ready_o, 0);
    chk({pfx, "_eval"},   evict_valid_o, 0);
    chk({pfx, "_busy"},   busy_o, 0);
    chk({pfx, "_done"},   done_o, 0);
    chk({pfx, "_flush"},  flushed_o, 0);
    chk({pfx, "_ind"},    store_indicator_o, 0);
    chk({pfx, "_idx"},    store_index_o, 0);
    chk({pfx, "_eway"},   evict_way_o, 0);
    chk({pfx, "_eidx"},   evict_index_o, 0);
    chk({pfx, "_etag"},   evict_tag_o, 0);
  endtask

  // A set is complete; the last set of a way marks the way flushed.
  function automatic void set_done(input logic [W-1:0] way, input logic [IL-1:0] idx);
    if (idx == IL'(N - 1)) flushed_m |= way;
  endfunction

  // ps/pr/pe/pk: percent chance of store ready, response valid, evict flag,
  // evict ready. exp_cyc >= 0 checks cycles from acceptance to done.
  task automatic run_cmd(input logic [W-1:0] mask, input int ps, input int pr,
                         input int pe, input int pk, input bit rst_ev, input int exp_cyc);
    rq_t reqq[$];
    ev_t evq[$];
    rq_t cur = '0;
    ev_t e;
    bit  outst = 0, seen_done = 0, active;
    int  cyc = 0, t = 0;
    for (int w = 0; w < W; w++)
      if (mask[w])
        for (int i = 0; i < N; i++) reqq.push_back('{way: W'(1) << w, idx: IL'(i)});
    while (!flush_ready_o && t < 50) begin @(negedge clk_i); t++; end
    chk("cmd_ready", flush_ready_o, 1);
    flush_way_i = mask; flush_valid_i = 1;
    flushed_m &= ~mask;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk_i); cyc++;
      idle_inputs();
      active = (reqq.size() > 0) || outst || (evq.size() > 0);
      chk("busy",    busy_o, active);
      chk("done",    done_o, !active);
      chk("fready",  flush_ready_o, !active);
      chk("flushed", flushed_o, flushed_m);
      chk("rrdy",    store_res_ready_o, outst);
      chk("eval",    evict_valid_o, evq.size() > 0);
      chk("sval",    store_valid_o, !outst && evq.size() == 0 && reqq.size() > 0);
      if (!active) begin
        seen_done = 1;
      end else if (rst_ev && evict_valid_o) begin
        rst_i = 1; #1;
        check_all_zero("rst_mid");
        @(negedge clk_i); rst_i = 0; #1;
        chk("rst_rel_ready", flush_ready_o, 1);
        flushed_m = '0;
        return;
      end else begin
        if (store_valid_o && reqq.size() > 0) begin
          chk("req_way", store_indicator_o, reqq[0].way);
          chk("req_idx", store_index_o, reqq[0].idx);
          if ($urandom_range(99) < ps) begin
            store_ready_i = 1; cur = reqq.pop_front(); outst = 1;
          end
        end else if (outst && store_res_ready_o) begin
          if ($urandom_range(99) < pr) begin
            store_res_valid_i = 1; outst = 0;
            store_res_tag_i = TL'($urandom);
            if ($urandom_range(99) < pe) begin
              store_res_evict_i = 1;
              evq.push_back('{way: cur.way, idx: cur.idx, tag: store_res_tag_i});
            end else set_done(cur.way, cur.idx);
          end
        end else if (evict_valid_o && evq.size() > 0) begin
          chk("ev_way", evict_way_o, evq[0].way);
          chk("ev_idx", evict_index_o, evq[0].idx);
          chk("ev_tag", evict_tag_o, evq[0].tag);
          if ($urandom_range(99) < pk) begin
            evict_ready_i = 1; e = evq.pop_front(); set_done(e.way, e.idx);
          end
        end
        // A command offered while busy must be ignored.
        if (busy_o && $urandom_range(3) == 0) begin
          flush_valid_i = 1; flush_way_i = W'($urandom);
        end
      end
    end
    chk("done_seen", seen_done, 1);
    if (exp_cyc >= 0) chk("cycles", cyc - 1, exp_cyc);
    @(negedge clk_i);
    chk("done_pulse", done_o, 0);
    chk("idle_busy",  busy_o, 0);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    @(negedge clk_i); @(negedge clk_i);
    check_all_zero("rst");
    rst_i = 0; #1;
    chk("rst_rel_ready", flush_ready_o, 1);
    @(negedge clk_i);
    // clean walk of one way: 2 cycles per set
    run_cmd(4'b0001, 100, 100, 0, 100, 0, 2 * N);
    // every set dirty: 3 cycles per set
    run_cmd(4'b0001, 100, 100, 100, 100, 0, 3 * N);
    // evictions with write-back backpressure
    run_cmd(4'b0001, 100, 100, 50, 25, 0, -1);
    // two ways, ascending order
    run_cmd(4'b1010, 100, 100, 0, 100, 0, 4 * N);
    // empty command: done one cycle later, no requests
    run_cmd(4'b0000, 100, 100, 0, 100, 0, 0);
    // store backpressure, other ways' flushed bits untouched
    run_cmd(4'b0100, 30, 100, 30, 50, 0, -1);
    for (int k = 0; k < 25; k++)
      run_cmd(W'($urandom), $urandom_range(100, 20), $urandom_range(100, 20),
              $urandom_range(100), $urandom_range(100, 20), 0, -1);
    // reset mid-eviction after some ways are already flushed
    run_cmd(4'b0110, 100, 100, 0, 100, 0, 2 * N * 2);
    run_cmd(4'b0001, 100, 100, 100, 0, 1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
